// File: rtl/pipe_ctrl_n_pkg.sv
// Shared types and stage index constants for the pipeline controller.
package pipe_ctrl_n_pkg;

  typedef enum logic [1:0] {
    DRN_IDLE,
    DRN_DRAIN,
    DRN_RELEASE
  } drain_state_e;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EXE = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

endpackage

// File: rtl/pipe_ctrl_n_if.sv
// Handshake bundle between pipeline stages (master) and the controller (slave).
interface pipe_ctrl_n_if #(
  parameter int unsigned NSTAGE = 5
);
  logic              if_valid;
  logic [NSTAGE-1:0] stage_ready;
  logic [NSTAGE-1:0] redirect_req;
  logic              drain_req;
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] flush;
  logic [NSTAGE-1:0] valid;
  logic              drain_busy;

  modport master (
    output if_valid, stage_ready, redirect_req, drain_req,
    input  stall, flush, valid, drain_busy
  );

  modport slave (
    input  if_valid, stage_ready, redirect_req, drain_req,
    output stall, flush, valid, drain_busy
  );
endinterface

// File: rtl/pipe_ctrl_n_perf_cnt.sv
// Wrapping event counter with enable, used for pipeline performance statistics.
module pipe_perf_cnt #(
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [PERF_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)     cnt <= '0;
    else if (en) cnt <= cnt + PERF_W'(1);
  end
endmodule

// File: rtl/pipe_ctrl_n.sv
// N-stage pipeline controller: occupancy, stall chain, oldest-wins flush, drain FSM.
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl_n
  import pipe_ctrl_n_pkg::*;
#(
  parameter int unsigned NSTAGE      = 5,
  parameter int unsigned DRAIN_STAGE = STG_ID
`ifdef PIPE_CTRL_PERF_EN
  , parameter int unsigned PERF_W    = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ctrl_n_if.slave      bus
`ifdef PIPE_CTRL_PERF_EN
  , output logic [PERF_W-1:0] perf_cyc
  , output logic [PERF_W-1:0] perf_ret
  , output logic [PERF_W-1:0] perf_stl
  , output logic [PERF_W-1:0] perf_fls
`endif
);

  logic [NSTAGE-1:1] valid_q;
  logic [NSTAGE-1:0] occ, stall_raw, flush_raw, stall_c, flush_c;
  drain_state_e      state_q, state_n;
  logic              older_busy;

  assign occ        = {valid_q, bus.if_valid};
  assign older_busy = |valid_q[NSTAGE-1:DRAIN_STAGE+1];

  // Each stage carries its own stall / "older redirect" bit so the chains are
  // built from distinct signals rather than a vector feeding back on itself.
  for (genvar i = 0; i < NSTAGE; i++) begin : g_stg
    logic stl, held, older_stl, fl_above;
    if (i == NSTAGE - 1) begin : g_top
      assign older_stl = 1'b0;
      assign fl_above  = 1'b0;
    end else begin : g_mid
      assign older_stl = g_stg[i+1].stl;
      assign fl_above  = g_stg[i+1].fl_above | bus.redirect_req[i+1];
    end
    if (i == DRAIN_STAGE) begin : g_hold
      assign held = (state_q == DRN_DRAIN);
    end else begin : g_nohold
      assign held = 1'b0;
    end
    assign stl          = occ[i] & (~bus.stage_ready[i] | older_stl | held);
    assign stall_raw[i] = stl;
    assign flush_raw[i] = fl_above;
  end

  assign flush_c = rst ? '1 : flush_raw;
  assign stall_c = rst ? '0 : (stall_raw & ~flush_raw);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      for (int unsigned i = 1; i < NSTAGE; i++) begin
        if (flush_c[i])      valid_q[i] <= 1'b0;
        else if (!stall_c[i]) valid_q[i] <= occ[i-1] & bus.stage_ready[i-1]
                                          & ~stall_c[i-1] & ~flush_c[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= DRN_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      DRN_IDLE:
        if (bus.drain_req && occ[DRAIN_STAGE] && !flush_c[DRAIN_STAGE] && older_busy)
          state_n = DRN_DRAIN;
      DRN_DRAIN:
        if (flush_c[DRAIN_STAGE]) state_n = DRN_IDLE;
        else if (!older_busy)     state_n = DRN_RELEASE;
      DRN_RELEASE:
        state_n = DRN_IDLE;
      default:
        state_n = DRN_IDLE;
    endcase
  end

  assign bus.stall      = stall_c;
  assign bus.flush      = flush_c;
  assign bus.valid      = occ;
  assign bus.drain_busy = (state_q != DRN_IDLE);

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt #(.PERF_W(PERF_W)) u_cyc (
    .clk(clk), .rst(rst), .en(1'b1), .cnt(perf_cyc));
  pipe_perf_cnt #(.PERF_W(PERF_W)) u_ret (
    .clk(clk), .rst(rst), .en(occ[NSTAGE-1] & bus.stage_ready[NSTAGE-1]), .cnt(perf_ret));
  pipe_perf_cnt #(.PERF_W(PERF_W)) u_stl (
    .clk(clk), .rst(rst), .en(stall_c[0]), .cnt(perf_stl));
  pipe_perf_cnt #(.PERF_W(PERF_W)) u_fls (
    .clk(clk), .rst(rst), .en(|bus.redirect_req), .cnt(perf_fls));
`endif

endmodule
